// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings and constants for the CPU pipeline
package cpu_pkg;
    typedef enum logic [1:0] {
        REDIR_NONE   = 2'b00,
        REDIR_BRANCH = 2'b01,
        REDIR_JUMP   = 2'b10,
        REDIR_JR     = 2'b11
    } redir_e;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
    typedef enum logic {ST_RUN, ST_HALT} fetch_state_e;
endpackage

// File: rtl/ifid_register.sv
// ifid_register: IF/ID pipeline register with flush, hold and load controls
module ifid_register
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);
    logic [31:0] instr_q, pc_plus4_q;
    logic        valid_q;
    // flush beats hold so a redirect or fault always leaves a bubble behind
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (!hold_i) begin
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
            valid_q    <= 1'b1;
        end
    end
    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC ownership, redirect resolution and illegal-PC halt
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] MEM_BYTES = 32'd16384
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic [1:0]  redirect_sel,
    input  logic [15:0] id_imm16,
    input  logic [25:0] id_target26,
    input  logic [31:0] id_jr_addr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        fault,
    output logic        halted
);
    logic [31:0]  pc_q, pc_d, seq, branch_tgt, jump_tgt, redir_tgt;
    logic         redir, illegal, run, fault_q, halted_q;
    fetch_state_e state_q;
    // target arithmetic and next-PC mux; redirects from a bubble are meaningless
    always_comb begin
        run        = state_q == ST_RUN;
        seq        = pc_q + PC_STEP;
        branch_tgt = ifid_pc_plus4 + {{14{id_imm16[15]}}, id_imm16, 2'b00};
        jump_tgt   = {ifid_pc_plus4[31:28], id_target26, 2'b00};
        redir      = ifid_valid && redirect_sel != REDIR_NONE;
        redir_tgt  = redirect_sel == REDIR_BRANCH ? branch_tgt :
                     redirect_sel == REDIR_JUMP   ? jump_tgt   : id_jr_addr;
        pc_d       = redir ? redir_tgt : stall ? pc_q : seq;
        illegal    = pc_d[1:0] != 2'b00 || pc_d >= MEM_BYTES;
    end
    // RUN/HALT FSM with registered PC and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            fault_q  <= 1'b0;
            halted_q <= 1'b0;
        end else if (run) begin
            if (illegal) begin
                state_q  <= ST_HALT;
                fault_q  <= 1'b1;
                halted_q <= 1'b1;
            end else begin
                pc_q <= pc_d;
            end
        end
    end
    ifid_register u_ifid (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (!run || illegal || redir),
        .hold_i     (stall),
        .instr_i    (instruction),
        .pc_plus4_i (seq),
        .instr_o    (ifid_instr),
        .pc_plus4_o (ifid_pc_plus4),
        .valid_o    (ifid_valid)
    );
    assign pc     = pc_q;
    assign fault  = fault_q;
    assign halted = halted_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scoreboard bench for the fetch stage
module tb_instruction_fetch;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        v;
        logic        f;
        logic        h;
    } snap_t;
    logic        clk = 0, reset = 1, stall = 0, ifid_valid, fault, halted;
    logic [1:0]  redirect_sel = 0;
    logic [15:0] id_imm16 = 0;
    logic [25:0] id_target26 = 0;
    logic [31:0] id_jr_addr = 0, pc, instruction, ifid_instr, ifid_pc_plus4;
    int          checks = 0, errors = 0, vec = 0;
    snap_t       exp_q[$];
    string       name_q[$];
    always #5 clk = ~clk;
    // memory model: address 0 holds 2008_0005, everything else returns 1000_0000|addr
    assign instruction = pc == 32'h0 ? 32'h2008_0005 : (32'h1000_0000 | pc);
    instruction_fetch dut (
        .clk(clk), .reset(reset), .pc(pc), .instruction(instruction), .stall(stall),
        .redirect_sel(redirect_sel), .id_imm16(id_imm16), .id_target26(id_target26),
        .id_jr_addr(id_jr_addr), .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4),
        .ifid_valid(ifid_valid), .fault(fault), .halted(halted)
    );
    // monitor: after each edge, compare DUT state against the oldest pending expectation
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            snap_t e, a;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = '{pc, ifid_instr, ifid_pc_plus4, ifid_valid, fault, halted};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got pc=%h instr=%h pp4=%h v=%b f=%b h=%b, expected pc=%h instr=%h pp4=%h v=%b f=%b h=%b",
                         n, a.pc, a.instr, a.pp4, a.v, a.f, a.h, e.pc, e.instr, e.pp4, e.v, e.f, e.h);
            end
        end
    end
    task automatic step(input string n, input logic r, input logic st, input logic [1:0] sel,
                        input logic [15:0] imm, input logic [25:0] t26, input logic [31:0] jr,
                        input logic [31:0] epc, input logic [31:0] ei, input logic [31:0] epp,
                        input logic ev, input logic ef, input logic eh);
        @(negedge clk);
        reset = r; stall = st; redirect_sel = sel;
        id_imm16 = imm; id_target26 = t26; id_jr_addr = jr;
        exp_q.push_back('{epc, ei, epp, ev, ef, eh});
        name_q.push_back(n);
        vec++;
    endtask
    initial begin
        step("reset",        1, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step("fetch0",       0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h4, 32'h2008_0005, 32'h4, 1, 0, 0);
        step("fetch4",       0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h8, 32'h1000_0004, 32'h8, 1, 0, 0);
        step("stall1",       0, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h8, 32'h1000_0004, 32'h8, 1, 0, 0);
        step("stall2",       0, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h8, 32'h1000_0004, 32'h8, 1, 0, 0);
        step("stall3",       0, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h8, 32'h1000_0004, 32'h8, 1, 0, 0);
        step("resume8",      0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'hC, 32'h1000_0008, 32'hC, 1, 0, 0);
        step("branch_stall", 0, 1, 2'b01, 16'hFFFE, 26'h0, 32'h0, 32'h4, 32'h0, 32'h0, 0, 0, 0);
        step("redir_bubble", 0, 0, 2'b10, 16'h0, 26'h3FF, 32'h0, 32'h8, 32'h1000_0004, 32'h8, 1, 0, 0);
        step("jump",         0, 0, 2'b10, 16'h0, 26'h100, 32'h0, 32'h400, 32'h0, 32'h0, 0, 0, 0);
        step("fetch400",     0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h404, 32'h1000_0400, 32'h404, 1, 0, 0);
        step("jr20",         0, 0, 2'b11, 16'h0, 26'h0, 32'h20, 32'h20, 32'h0, 32'h0, 0, 0, 0);
        step("fetch20",      0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h24, 32'h1000_0020, 32'h24, 1, 0, 0);
        step("jr_misalign",  0, 0, 2'b11, 16'h0, 26'h0, 32'h22, 32'h24, 32'h0, 32'h0, 0, 1, 1);
        step("halt_ignore",  0, 0, 2'b11, 16'h0, 26'h0, 32'h40, 32'h24, 32'h0, 32'h0, 0, 1, 1);
        step("halt_hold",    0, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h24, 32'h0, 32'h0, 0, 1, 1);
        step("reset_halt",   1, 0, 2'b11, 16'h0, 26'h0, 32'h40, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step("refetch0",     0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h4, 32'h2008_0005, 32'h4, 1, 0, 0);
        step("jr3ff8",       0, 0, 2'b11, 16'h0, 26'h0, 32'h3FF8, 32'h3FF8, 32'h0, 32'h0, 0, 0, 0);
        step("fetch3ff8",    0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3FFC, 32'h1000_3FF8, 32'h3FFC, 1, 0, 0);
        step("seq_oob",      0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3FFC, 32'h0, 32'h0, 0, 1, 1);
        step("reset2",       1, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step("fetch0b",      0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h4, 32'h2008_0005, 32'h4, 1, 0, 0);
        step("br_underflow", 0, 0, 2'b01, 16'hFFFE, 26'h0, 32'h0, 32'h4, 32'h0, 32'h0, 0, 1, 1);
        step("reset3",       1, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step("stall_oob_ok", 0, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step("fetch0c",      0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h4, 32'h2008_0005, 32'h4, 1, 0, 0);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0 || checks != vec) begin
            errors++;
            $display("FAIL drain: %0d checks made, %0d required", checks, vec);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
